// File: rtl/inchar_uart_rx.sv
// ============================================================================
// Module   : inchar_uart_rx
// Purpose  : 8N1 UART receiver with a start/result_ready call handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inchar_uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       in_uart_rxd,
  output logic [7:0] result,
  output logic       framing_error,
  output logic       result_ready
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [2:0] ST_READY = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  localparam logic [CW-1:0] c_half_last = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] c_bit_last  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] c_zero      = '0;
  localparam logic [CW-1:0] c_one       = CW'(1);

  logic          rx_meta_q;
  logic          rx_s_q;
  logic [2:0]    state_q,  state_d;
  logic [CW-1:0] count_q,  count_d;
  logic [2:0]    idx_q,    idx_d;
  logic [7:0]    shift_q,  shift_d;
  logic [7:0]    result_q, result_d;
  logic          ferr_q,   ferr_d;
  logic          armed_q,  armed_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= in_uart_rxd;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    result_d = result_q;
    ferr_d   = ferr_q;
    armed_d  = armed_q;

    case (state_q)
      ST_READY: begin
      end

      // Arming on a high line keeps a break or stuck-low line from being
      // mistaken for a start bit.
      ST_WAIT: begin
        if (armed_q && !rx_s_q) begin
          state_d = ST_CHECK;
          count_d = c_zero;
        end else if (rx_s_q) begin
          armed_d = 1'b1;
        end
      end

      ST_CHECK: begin
        if (count_q == c_half_last) begin
          count_d = c_zero;
          if (!rx_s_q) begin
            state_d = ST_DATA;
            idx_d   = 3'd0;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          count_d = count_q + c_one;
        end
      end

      ST_DATA: begin
        if (count_q == c_bit_last) begin
          count_d        = c_zero;
          shift_d[idx_q] = rx_s_q;
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          count_d = count_q + c_one;
        end
      end

      ST_STOP: begin
        if (count_q == c_bit_last) begin
          count_d  = c_zero;
          result_d = shift_q;
          ferr_d   = ~rx_s_q;
          state_d  = ST_READY;
        end else begin
          count_d = count_q + c_one;
        end
      end

      default: begin
        state_d = ST_READY;
        count_d = c_zero;
      end
    endcase

    // A new call overrides whatever the receiver was doing this cycle.
    if (start) begin
      state_d = ST_WAIT;
      armed_d = 1'b0;
      count_d = c_zero;
      idx_d   = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_READY;
      count_q  <= c_zero;
      idx_q    <= 3'd0;
      shift_q  <= 8'd0;
      result_q <= 8'd0;
      ferr_q   <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      result_q <= result_d;
      ferr_q   <= ferr_d;
      armed_q  <= armed_d;
    end
  end

  assign result        = result_q;
  assign framing_error = ferr_q;
  assign result_ready  = (state_q == ST_READY) & ~start;

endmodule

`default_nettype wire

// File: tb/tb_inchar_uart_rx.sv
// ============================================================================
// Module   : tb_inchar_uart_rx
// Purpose  : Directed self-checking bench for inchar_uart_rx (16 clks/bit).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inchar_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = 8;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       in_uart_rxd;
  logic [7:0] result;
  logic       framing_error;
  logic       result_ready;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int t_rise = -1;
  int t_start;
  logic rdy_prev = 1'b1;
  logic seen_low = 1'b0;

  inchar_uart_rx #(
    .CLKS_PER_BIT (CPB),
    .HALF_BIT     (HALF)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .in_uart_rxd   (in_uart_rxd),
    .result        (result),
    .framing_error (framing_error),
    .result_ready  (result_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Rising-edge timestamp and low detector for result_ready, sampled mid-cycle.
  always @(negedge clk) begin
    if (result_ready && !rdy_prev) t_rise = cyc;
    if (!result_ready) seen_low = 1'b1;
    rdy_prev = result_ready;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; leaves the bench at a negedge.
  task automatic pulse_start(input string tag);
    start = 1'b1;
    #1;
    check(tag, {31'd0, result_ready}, 32'd0);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    in_uart_rxd = b;
    idle(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic wait_ready(input string tag, input int max);
    for (int n = 0; n < max; n++) begin
      if (result_ready) break;
      @(negedge clk);
    end
    check(tag, {31'd0, result_ready}, 32'd1);
  endtask

  initial begin
    reset_n     = 1'b0;
    start       = 1'b0;
    in_uart_rxd = 1'b1;
    idle(3);
    reset_n = 1'b1;
    idle(2);

    check("reset_ready", {31'd0, result_ready}, 32'd1);
    check("reset_result", {24'd0, result}, 32'h00);
    check("reset_ferr", {31'd0, framing_error}, 32'd0);

    // 0x41 with exact latency: ready seen 155 posedges after the line drops.
    pulse_start("start1_ready_low");
    idle(4);
    check("wait_ready_low", {31'd0, result_ready}, 32'd0);
    t_start = cyc;
    send_frame(8'h41, 1'b1);
    wait_ready("rx41_done", 50);
    check("rx41_latency", t_rise - t_start, 32'd155);
    check("rx41_result", {24'd0, result}, 32'h41);
    check("rx41_ferr", {31'd0, framing_error}, 32'd0);

    // Short glitch is rejected at the mid-start-bit check.
    pulse_start("start2_ready_low");
    idle(8);
    in_uart_rxd = 1'b0;
    idle(5);
    in_uart_rxd = 1'b1;
    idle(20);
    check("glitch_no_ready", {31'd0, result_ready}, 32'd0);
    check("glitch_result_kept", {24'd0, result}, 32'h41);
    send_frame(8'hA5, 1'b1);
    wait_ready("rxA5_done", 50);
    check("rxA5_result", {24'd0, result}, 32'hA5);
    check("rxA5_ferr", {31'd0, framing_error}, 32'd0);

    // Framing error, then a stuck-low line must not start a frame.
    pulse_start("start3_ready_low");
    idle(8);
    send_frame(8'h3C, 1'b0);
    wait_ready("rx3C_done", 50);
    check("rx3C_result", {24'd0, result}, 32'h3C);
    check("rx3C_ferr", {31'd0, framing_error}, 32'd1);
    pulse_start("start4_ready_low");
    idle(200);
    check("stuck_low_no_ready", {31'd0, result_ready}, 32'd0);
    check("stuck_low_result", {24'd0, result}, 32'h3C);
    in_uart_rxd = 1'b1;
    idle(32);
    send_frame(8'h55, 1'b1);
    wait_ready("rx55_done", 50);
    check("rx55_result", {24'd0, result}, 32'h55);
    check("rx55_ferr", {31'd0, framing_error}, 32'd0);

    // Restart midway through bit 4 of a frame.
    pulse_start("start5_ready_low");
    idle(8);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    in_uart_rxd = 1'b0;
    idle(HALF);
    pulse_start("abort_ready_low");
    in_uart_rxd = 1'b1;
    idle(40);
    check("abort_no_ready", {31'd0, result_ready}, 32'd0);
    check("abort_result_kept", {24'd0, result}, 32'h55);
    send_frame(8'h7E, 1'b1);
    wait_ready("rx7E_done", 50);
    check("rx7E_result", {24'd0, result}, 32'h7E);
    check("rx7E_ferr", {31'd0, framing_error}, 32'd0);

    // Asynchronous reset during bit 3.
    pulse_start("start6_ready_low");
    idle(8);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    in_uart_rxd = 1'b1;
    idle(HALF);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_result", {24'd0, result}, 32'h00);
    check("async_rst_ferr", {31'd0, framing_error}, 32'd0);
    idle(3);
    reset_n = 1'b1;
    idle(2);
    check("post_rst_ready", {31'd0, result_ready}, 32'd1);
    check("post_rst_result", {24'd0, result}, 32'h00);

    // Byte with no call pending is dropped.
    seen_low = 1'b0;
    send_frame(8'h99, 1'b1);
    idle(30);
    check("nocall_result", {24'd0, result}, 32'h00);
    check("nocall_ready", {31'd0, result_ready}, 32'd1);
    check("nocall_ready_never_low", {31'd0, seen_low}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
